// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: 16x-oversampled 8N1 UART receiver with valid/ready output and framing/overrun flags
module uart_rx_oversampler #(
  parameter int DATA_BITS = 8
) (
  input  logic                 system_clk,
  input  logic                 reset,
  input  logic                 rxclk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t               state_q, state_d;
  logic                 sync_q, rx_s_q;
  logic [3:0]           sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
  logic                 complete, load;
  // two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge system_clk or negedge reset)
    if (!reset) {sync_q, rx_s_q} <= 2'b11;
    else {sync_q, rx_s_q} <= {rx, sync_q};
  // frame FSM: everything advances only on a 16x strobe, deciding at bit centres
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    complete     = 1'b0;
    if (rxclk_en) begin
      sample_cnt_d = sample_cnt_q + 4'd1;
      case (state_q)
        IDLE: begin
          sample_cnt_d = '0;
          state_d      = rx_s_q ? IDLE : START;
        end
        START: if (sample_cnt_q == 4'd7) begin
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          state_d      = rx_s_q ? IDLE : DATA;
        end
        DATA: if (sample_cnt_q == 4'd15) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BW'(DATA_BITS - 1)) ? STOP : DATA;
        end
        STOP: if (sample_cnt_q == 4'd15) begin
          complete    = rx_s_q;
          frame_err_d = !rx_s_q;
          state_d     = rx_s_q ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: state_d = rx_s_q ? IDLE : WAIT_IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // output handshake: a completed byte loads unless the previous one is still unconsumed
  always_comb begin
    overrun_err_d = complete && rx_valid_q && !rx_ready;
    load          = complete && !overrun_err_d;
    rx_data_d     = load ? shift_q : rx_data_q;
    rx_valid_d    = load || (rx_valid_q && !rx_ready);
  end
  // state and datapath registers
  always_ff @(posedge system_clk or negedge reset)
    if (!reset) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = state_q != IDLE;
endmodule

// File: doc/uart_rx_oversampler.md
# uart_rx_oversampler

UART receiver that consumes the 16x-oversampled receive strobe from the baud-rate generator and the asynchronous serial line. It recovers 8N1-style frames (LSB first, one start bit, one stop bit) by sampling at bit centres. It presents each byte through a valid/ready handshake and flags framing and overrun errors. It sits between the pad-side rx pin and the UART's byte-level consumer, and is the receive-side counterpart of the baud generation logic.

## Interface
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- system_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rxclk_en  in  1  single-cycle strobe at 16x baud rate.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_BITS  received byte, LSB = first data bit.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when high with rx_valid.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overrun_err  out  1  one-cycle pulse when a byte completes while rx_valid is still high.
- busy  out  1  high in any state other than IDLE.

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value rx_s.
- sample_cnt is 4 bits and advances only on rxclk_en. bit_cnt is $clog2(DATA_BITS) bits. The shift register is DATA_BITS wide.
- IDLE: on a strobe with rx_s==0, clear sample_cnt and go to START.
- START: count strobes. At the strobe where sample_cnt==7 (mid start bit):
  - rx_s==1: glitch; return to IDLE.
  - rx_s==0: clear sample_cnt and bit_cnt; go to DATA.
- DATA: at the strobe where sample_cnt==15, shift rx_s in from the MSB side (right shift), so the first bit ends in bit 0 after DATA_BITS shifts. sample_cnt wraps 15->0. After shifting bit DATA_BITS-1, go to STOP.
- STOP: at the strobe where sample_cnt==15:
  - rx_s==1: complete the byte and go to IDLE.
  - rx_s==0: pulse frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1 on a strobe, then go to IDLE. This prevents a break condition from being taken as a start bit.
- Byte completion:
  - rx_valid==0, or rx_valid==1 with rx_ready==1 in the same cycle: load rx_data and set rx_valid.
  - rx_valid==1 with rx_ready==0: pulse overrun_err. The new byte is dropped; rx_data and rx_valid are unchanged.
- Handshake: when rx_valid&&rx_ready with no completion in that cycle, clear rx_valid at the next edge. rx_data holds its value until the next load.
- rxclk_en low: all counters and state hold. A rx change between strobes is seen only at the next strobe.
- reset low, at any time and including mid-frame: immediately force state IDLE, counters 0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, overrun_err 0, busy 0, synchronizer flops 1.

## Timing
- Input latency: 2 system_clk cycles from rx to rx_s.
- Start bit is confirmed 8 strobes after the first low strobe. Each data and stop bit is sampled 16 strobes after the previous sample.
- rx_valid rises on the edge after the stop-bit sample strobe. frame_err and overrun_err pulse on that same edge, for exactly one cycle.
- Returning to IDLE at the stop-bit centre leaves half a bit of slack for the next start edge. Back-to-back frames are received with no lost byte.
- rx_valid stays high until the cycle after rx_ready is sampled high. Minimum consume-to-reload gap is 0 cycles (simultaneous completion and accept).
- busy is combinational from state: high for the cycle START is entered through the cycle IDLE is re-entered.

## Test plan
- rxclk_en tied high (bit = 16 cycles), rx_ready=1, send 0xA5 -> one-cycle rx_valid with rx_data=0xA5; frame_err=0, overrun_err=0.
- Drive rx low for 4 strobes, then high -> busy rises then falls before DATA; no rx_valid, no errors.
- Send 0x3C with stop bit 0, hold rx low 3 bit-times, release, then send 0x5A -> frame_err pulses once and 0x3C is not delivered; the block waits in WAIT_IDLE; 0x5A is delivered correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid high with 0x11; overrun_err pulses at the 0x22 stop sample; rx_data stays 0x11; raising rx_ready drops rx_valid on the next edge.
- Assert reset mid-DATA of 0x77 -> all outputs 0 at once; after release, send 0xFF -> 0xFF received cleanly.
- rxclk_en pulsed every 7 cycles, send 0x00 then 0x80 back-to-back -> both bytes delivered in order, no errors; bit centres fall at strobe 7 + 16k.
